// File: rtl/calc_sequencer_if.sv
// ============================================================================
//  Module      : calc_sequencer_if
//  Description : Button, ALU handshake and status bundle for calc_sequencer.
//                slave  = sequencer side, master = board/ALU side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface calc_sequencer_if;
    logic       btnLoadA;
    logic       btnLoadB;
    logic       btnExec;
    logic [1:0] op_in;
    logic       alu_done;
    logic       loadA;
    logic       loadB;
    logic [1:0] alu_op;
    logic       alu_start;
    logic       result_valid;
    logic       busy;
    logic       err;
    logic       chainA;
    logic [2:0] state_dbg;

    modport slave (
        input  btnLoadA, btnLoadB, btnExec, op_in, alu_done,
        output loadA, loadB, alu_op, alu_start, result_valid, busy, err, chainA, state_dbg
    );

    modport master (
        output btnLoadA, btnLoadB, btnExec, op_in, alu_done,
        input  loadA, loadB, alu_op, alu_start, result_valid, busy, err, chainA, state_dbg
    );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
//  Module      : calc_sequencer
//  Description : Calculator control FSM. Debounces LoadA/LoadB/Exec buttons,
//                pulses operand load enables and runs one ALU op through a
//                start/done handshake with a timeout to ERR.
//                Optional macro CALC_CHAIN_EN: Exec in DONE pulses chainA
//                (A <= result) instead of re-issuing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module calc_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd64
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low
    calc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Button index order: 0 = LoadA, 1 = LoadB, 2 = Exec
    logic [2:0] w_raw;
    logic [2:0] w_pulse;

    assign w_raw = {bus.btnExec, bus.btnLoadB, bus.btnLoadA};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic        sync1_q;
        logic        sync2_q;
        logic        level_q;
        logic        pulse_q;
        logic [15:0] cnt_q;

        // Synchronize, then accept a new level only after it has been stable long enough;
        // a rising accepted level yields a one-cycle pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= 16'd0;
            end else begin
                sync1_q <= w_raw[gi];
                sync2_q <= sync1_q;
                pulse_q <= 1'b0;
                if (sync2_q == level_q) begin
                    cnt_q <= 16'd0;
                end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    level_q <= sync2_q;
                    pulse_q <= sync2_q;
                    cnt_q   <= 16'd0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end

        assign w_pulse[gi] = pulse_q;
    end

    logic w_pa;
    logic w_pb;
    logic w_px;

    assign w_pa = w_pulse[0];
    assign w_pb = w_pulse[1];
    assign w_px = w_pulse[2];

    state_t      state_q;
    logic        a_ok_q;
    logic        b_ok_q;
    logic [15:0] tmo_q;
    logic        loadA_q;
    logic        loadB_q;
    logic [1:0]  alu_op_q;
    logic        alu_start_q;
    logic        result_valid_q;
    logic        busy_q;
    logic        err_q;
`ifdef CALC_CHAIN_EN
    logic        chainA_q;
`endif

    // Sequencer FSM with registered Moore outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            a_ok_q         <= 1'b0;
            b_ok_q         <= 1'b0;
            tmo_q          <= 16'd0;
            loadA_q        <= 1'b0;
            loadB_q        <= 1'b0;
            alu_op_q       <= 2'b00;
            alu_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef CALC_CHAIN_EN
            chainA_q       <= 1'b0;
`endif
        end else begin
            loadA_q     <= 1'b0;
            loadB_q     <= 1'b0;
            alu_start_q <= 1'b0;
`ifdef CALC_CHAIN_EN
            chainA_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Loads take priority; a coincident Exec is dropped.
                    if (w_pa || w_pb) begin
                        loadA_q        <= w_pa;
                        loadB_q        <= w_pb;
                        if (w_pa) a_ok_q <= 1'b1;
                        if (w_pb) b_ok_q <= 1'b1;
                        result_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
`ifdef CALC_CHAIN_EN
                    else if (w_px && (state_q == S_DONE)) begin
                        chainA_q       <= 1'b1;
                        result_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
`endif
                    else if (w_px && a_ok_q && b_ok_q) begin
                        alu_start_q    <= 1'b1;
                        alu_op_q       <= bus.op_in;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                        tmo_q          <= 16'd0;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= 16'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Done on the terminal count still completes normally.
                    if (bus.alu_done) begin
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_ERR: begin
                    // Only Exec recovers; operands must be reloaded afterwards.
                    if (w_px) begin
                        err_q   <= 1'b0;
                        a_ok_q  <= 1'b0;
                        b_ok_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.loadA        = loadA_q;
    assign bus.loadB        = loadB_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_start    = alu_start_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.state_dbg    = state_q;
`ifdef CALC_CHAIN_EN
    assign bus.chainA       = chainA_q;
`else
    assign bus.chainA       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Directed self-checking bench for calc_sequencer
//                (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8) with an ALU-op scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_calc_sequencer;

    logic clk;
    logic rst;

    calc_sequencer_if bus ();

    calc_sequencer #(
        .DEBOUNCE_CYCLES (16'd4),
        .TIMEOUT_CYCLES  (16'd8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int n_loada = 0;
    int n_loadb = 0;
    int n_start = 0;
    int n_chain = 0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    // Monitor: count high cycles of each pulse output and log the op at every start.
    always @(posedge clk) begin
        #1;
        if (bus.loadA === 1'b1)  n_loada++;
        if (bus.loadB === 1'b1)  n_loadb++;
        if (bus.chainA === 1'b1) n_chain++;
        if (bus.alu_start === 1'b1) begin
            n_start++;
            obs_q.push_back(bus.alu_op);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0:       bus.btnLoadA = v;
            1:       bus.btnLoadB = v;
            default: bus.btnExec  = v;
        endcase
    endtask

    task automatic press(input int idx, input int hold);
        set_btn(idx, 1'b1);
        tick(hold);
        set_btn(idx, 1'b0);
        tick(10);
    endtask

    task automatic sb_compare(input string tag);
        logic [1:0] e;
        logic [1:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, 32'(obs_q.size()), 32'd1);
            end else begin
                o = obs_q.pop_front();
                chk(tag, {30'd0, o}, {30'd0, e});
            end
        end
    endtask

    // Press Exec, expect an issue, then optionally return alu_done dly cycles after start.
    task automatic do_issue(input string tag, input logic [1:0] op, input int dly);
        bit seen;
        bus.op_in = op;
        exp_q.push_back(op);
        bus.btnExec = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick(1);
            if (bus.alu_start === 1'b1) seen = 1'b1;
        end
        bus.btnExec = 1'b0;
        chk({tag, "_start_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_issue_state"}, {29'd0, bus.state_dbg}, 32'd1);
        chk({tag, "_issue_busy"}, {31'd0, bus.busy}, 32'd1);
        sb_compare({tag, "_op"});
        bus.op_in = ~op;
        tick(1);
        chk({tag, "_op_held"}, {30'd0, bus.alu_op}, {30'd0, op});
        chk({tag, "_start_low"}, {31'd0, bus.alu_start}, 32'd0);
        chk({tag, "_wait_state"}, {29'd0, bus.state_dbg}, 32'd2);
        if (dly > 0) begin
            tick(dly - 1);
            bus.alu_done = 1'b1;
            tick(1);
            bus.alu_done = 1'b0;
            chk({tag, "_done_state"}, {29'd0, bus.state_dbg}, 32'd3);
            chk({tag, "_result_valid"}, {31'd0, bus.result_valid}, 32'd1);
            chk({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
            tick(8);
            chk({tag, "_rv_held"}, {31'd0, bus.result_valid}, 32'd1);
        end
    endtask

    initial begin
        int a0, b0, s0, c0;
        rst          = 1'b0;
        bus.btnLoadA = 1'b0;
        bus.btnLoadB = 1'b0;
        bus.btnExec  = 1'b0;
        bus.op_in    = 2'b00;
        bus.alu_done = 1'b0;
        tick(3);

        // Reset state
        chk("rst_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("rst_loadA", {31'd0, bus.loadA}, 32'd0);
        chk("rst_loadB", {31'd0, bus.loadB}, 32'd0);
        chk("rst_start", {31'd0, bus.alu_start}, 32'd0);
        chk("rst_op", {30'd0, bus.alu_op}, 32'd0);
        chk("rst_rv", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_chain", {31'd0, bus.chainA}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Load A, load B, execute add
        a0 = n_loada; b0 = n_loadb;
        press(0, 8);
        chk("t1_loadA_once", 32'(n_loada - a0), 32'd1);
        chk("t1_loadB_none", 32'(n_loadb - b0), 32'd0);
        press(1, 8);
        chk("t1_loadB_once", 32'(n_loadb - b0), 32'd1);
        chk("t1_loadA_still", 32'(n_loada - a0), 32'd1);
        do_issue("t1", 2'b00, 3);

        // Load in DONE returns to IDLE and drops result_valid
        a0 = n_loada;
        press(0, 8);
        chk("done_load_cnt", 32'(n_loada - a0), 32'd1);
        chk("done_load_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("done_load_rv", {31'd0, bus.result_valid}, 32'd0);

        // Timeout to ERR
        do_issue("t3", 2'b01, 0);
        tick(7);
        chk("t3_last_wait", {29'd0, bus.state_dbg}, 32'd2);
        chk("t3_err_not_yet", {31'd0, bus.err}, 32'd0);
        tick(1);
        chk("t3_err_state", {29'd0, bus.state_dbg}, 32'd4);
        chk("t3_err", {31'd0, bus.err}, 32'd1);
        chk("t3_busy_low", {31'd0, bus.busy}, 32'd0);
        a0 = n_loada; s0 = n_start;
        press(0, 8);
        chk("t3_load_ignored", 32'(n_loada - a0), 32'd0);
        chk("t3_still_err", {29'd0, bus.state_dbg}, 32'd4);
        press(2, 8);
        chk("t3_recover_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("t3_recover_err", {31'd0, bus.err}, 32'd0);
        press(2, 8);
        chk("t3_flags_cleared", 32'(n_start - s0), 32'd0);

        // Exec with only A loaded is dropped; then B and Exec issue
        s0 = n_start;
        press(0, 8);
        press(2, 8);
        chk("t2_no_start", 32'(n_start - s0), 32'd0);
        chk("t2_idle", {29'd0, bus.state_dbg}, 32'd0);
        press(1, 8);
        do_issue("t2", 2'b10, 1);

        // Glitch rejected; long press gives exactly one load
        a0 = n_loada;
        bus.btnLoadA = 1'b1;
        tick(2);
        bus.btnLoadA = 1'b0;
        tick(10);
        chk("t4_glitch", 32'(n_loada - a0), 32'd0);
        chk("t4_glitch_state", {29'd0, bus.state_dbg}, 32'd3);
        press(0, 20);
        chk("t4_held_once", 32'(n_loada - a0), 32'd1);
        chk("t4_held_state", {29'd0, bus.state_dbg}, 32'd0);

        // alu_done on the terminal WAIT cycle wins over timeout
        do_issue("term", 2'b11, 8);
        chk("term_no_err", {31'd0, bus.err}, 32'd0);

        // Exec in DONE: chain or re-issue depending on build
`ifdef CALC_CHAIN_EN
        c0 = n_chain; s0 = n_start;
        press(2, 8);
        chk("t6_chain_once", 32'(n_chain - c0), 32'd1);
        chk("t6_no_start", 32'(n_start - s0), 32'd0);
        chk("t6_idle", {29'd0, bus.state_dbg}, 32'd0);
        do_issue("t6", 2'b01, 3);
`else
        c0 = n_chain;
        do_issue("t6", 2'b01, 3);
        chk("t6_chain_zero", 32'(n_chain - c0), 32'd0);
`endif

        // Asynchronous reset during WAIT
        do_issue("t5", 2'b10, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_op", {30'd0, bus.alu_op}, 32'd0);
        chk("t5_err", {31'd0, bus.err}, 32'd0);
        tick(2);
        rst = 1'b1;
        bus.alu_done = 1'b1;
        tick(1);
        bus.alu_done = 1'b0;
        tick(1);
        chk("t5_late_done_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("t5_late_done_rv", {31'd0, bus.result_valid}, 32'd0);
        s0 = n_start;
        press(2, 8);
        chk("t5_flags_cleared", 32'(n_start - s0), 32'd0);

        chk("sb_leftover", 32'(obs_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
